biquad_sequencer: RTL and testbench
===================================

# biquad_sequencer

Control block for the stereo biquad low-pass path. It turns the asynchronous DAC LR clock into a clean one-cycle `new_sample` strobe. It owns the filter coefficient set: coefficient presets are fetched from a small ROM and loaded into the shared `a0..b2` bus. Loads happen only just after a sample boundary, followed by a single `new_coefficients` pulse. Both biquad instances, left and right, take all their control and coefficient inputs from this block.

## Interface
- `COEF_W`, 18: coefficient width, signed Q2.16.
- `NUM_PRESETS`, 8: number of coefficient presets in the ROM.
- `SYNC_STAGES`, 2: synchronizer flops on `AUD_DACLRCK`.
- `CLOCK_50  in  1`: system clock, 50 MHz; the only clock.
- `Reset_n  in  1`: asynchronous, active-low reset.
- `AUD_DACLRCK  in  1`: codec LR clock, asynchronous to `CLOCK_50`.
- `filter_enable  in  1`: when 0, `new_sample` pulses are suppressed.
- `preset_req  in  1`: one-cycle request to load `preset_sel`.
- `preset_sel  in  $clog2(NUM_PRESETS)`: preset index, sampled when `preset_req`=1.
- `new_sample  out  1`: one-cycle strobe per LRCK rising edge.
- `new_coefficients  out  1`: one-cycle strobe; coefficients are stable and valid.
- `a0, a1, a2, b1, b2  out  COEF_W signed`: coefficient bus.
- `preset_active  out  $clog2(NUM_PRESETS)`: preset currently on the bus.
- `busy  out  1`: a load is pending or in progress.

## Operation
- **LRCK handling.** `AUD_DACLRCK` passes through `SYNC_STAGES` flops. A rising-edge detect on the synchronized signal gives `edge`.
- **`new_sample`.**
  - `new_sample` = `edge` AND `filter_enable`.
  - It is never suppressed by the FSM.
- **Pending request.** One-deep register holding `pend_valid` and `pend_idx`.
  - `preset_req` sets the register. A later request before service overwrites `pend_idx`.
  - A request that arrives in the same cycle the FSM consumes the pending register is kept, and is serviced by the next load.
- **FSM states:** IDLE, WAIT_EDGE, FETCH, STROBE.
  - IDLE → WAIT_EDGE when `pend_valid`. On that transition, latch `pend_idx` into `load_idx` and clear `pend_valid`.
  - WAIT_EDGE → FETCH on `edge`, regardless of `filter_enable`.
  - FETCH runs 6 cycles with counter k = 0..5:
    - For k < 5, drive ROM address `load_idx*5+k`.
    - For k > 0, capture the ROM data into coefficient k-1, in the order a0, a1, a2, b1, b2.
  - FETCH → STROBE after k = 5.
  - STROBE asserts `new_coefficients`, updates `preset_active` to `load_idx`, then goes → IDLE.
- Coefficient outputs change only during FETCH. They hold their value in every other state.
- `busy` = (`pend_valid` OR state ≠ IDLE).
- A request for the already-active preset is still executed in full.
- **Reset values:**
  - State IDLE, `a0..b2` = 0, `preset_active` = 0.
  - `new_sample` = 0, `new_coefficients` = 0.
  - The synchronizer flops are 0.
  - `pend_valid` = 1 with `pend_idx` = 0, so preset 0 is auto-loaded at the first LRCK edge. `busy` therefore reads 1 out of reset.
- **Reset mid-load:** the load is aborted and all reset values apply; there are no partial-update strobes.

## Timing
- `new_sample` is asserted between SYNC_STAGES+1 and SYNC_STAGES+2 `CLOCK_50` cycles after the LRCK rising edge.
- Let the `edge` cycle be E:
  - FETCH runs E+1..E+6; a0 updates at E+2 and b2 at E+6.
  - `new_coefficients` and the `preset_active` update occur at E+7.
  - The FSM is IDLE at E+8.
- Latency from request to strobe:
  - From `preset_req` to WAIT_EDGE is 2 cycles.
  - After that, the load waits for the next edge plus 7 cycles.
- The full load (8 cycles) completes well inside one LRCK period (about 1042 cycles), so a load never straddles a sample.

## Structure
- Package `biquad_pkg` holds:
  - `COEF_W`
  - the state enum `seq_state_t`
  - the coefficient index enum (A0, A1, A2, B1, B2)
  - the preset table constant `PRESET_COEFS[NUM_PRESETS][5]`
- Preset 0 is passthrough: a0 = 65536, all others 0.
- Sub-module `biquad_coef_rom` is a synchronous-read ROM with 1-cycle latency. Its depth is NUM_PRESETS*5 and it is initialized from `PRESET_COEFS`.

## Test plan
- **Reset then LRCK.** Release reset, toggle LRCK at 48 kHz.
  - First edge gives a `new_sample` pulse exactly 1 cycle wide.
  - Bus loads preset 0: a0 = 65536, others 0.
  - `new_coefficients` fires at E+7; `busy` falls at E+8.
- **`filter_enable` = 0.** Toggle LRCK 4 times → no `new_sample` pulses, but a pending preset load still completes.
- **Request preset 3 mid-frame.** Coefficient outputs stay unchanged until the cycle after the next `edge`. All 5 outputs equal `PRESET_COEFS[3]` at E+7. `preset_active` = 3.
- **Back-to-back requests.** Requests for 2 then 5 before the edge → only preset 5 is loaded. A request for 6 during FETCH → preset 6 loads after the following edge.
- **Reset mid-FETCH at E+3.**
  - All outputs return to 0; no `new_coefficients` pulse.
  - Preset 0 reloads at the next edge.
- **LRCK glitch-free check.** Drive LRCK asynchronous with a random phase to `CLOCK_50` → exactly one `new_sample` per rising edge over 1000 frames.

Source files
------------

// File: rtl/biquad_pkg.sv
// Shared types, sizes and the coefficient preset table for the biquad control path.
package biquad_pkg;

  localparam int COEF_W      = 18;
  localparam int NUM_PRESETS = 8;
  localparam int NUM_COEFS   = 5;
  localparam int PRESET_W    = $clog2(NUM_PRESETS);
  localparam int ROM_DEPTH   = NUM_PRESETS * NUM_COEFS;
  localparam int ROM_AW      = $clog2(ROM_DEPTH);

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    FETCH     = 2'd2,
    STROBE    = 2'd3
  } seq_state_t;

  typedef enum logic [2:0] {
    A0 = 3'd0,
    A1 = 3'd1,
    A2 = 3'd2,
    B1 = 3'd3,
    B2 = 3'd4
  } coef_idx_t;

  // Q2.16 presets, order a0, a1, a2, b1, b2. Preset 0 is a straight passthrough.
  localparam coef_t PRESET_COEFS [NUM_PRESETS][NUM_COEFS] = '{
    '{ 18'sd65536, 18'sd0,     18'sd0,     18'sd0,      18'sd0     },
    '{ 18'sd4096,  18'sd8192,  18'sd4096,  -18'sd98304, 18'sd40960 },
    '{ 18'sd8192,  18'sd16384, 18'sd8192,  -18'sd81920, 18'sd32768 },
    '{ 18'sd12288, 18'sd24576, 18'sd12288, -18'sd65536, 18'sd24576 },
    '{ 18'sd16384, 18'sd32768, 18'sd16384, -18'sd49152, 18'sd16384 },
    '{ 18'sd20480, 18'sd40960, 18'sd20480, -18'sd32768, 18'sd12288 },
    '{ 18'sd24576, 18'sd49152, 18'sd24576, -18'sd16384, 18'sd8192  },
    '{ 18'sd28672, 18'sd57344, 18'sd28672, 18'sd0,      18'sd4096  }
  };

  // Flat ROM address of coefficient k within preset idx.
  function automatic logic [ROM_AW-1:0] rom_addr(input logic [PRESET_W-1:0] idx,
                                                 input logic [2:0] k);
    return ROM_AW'(idx) * ROM_AW'(NUM_COEFS) + ROM_AW'(k);
  endfunction

endpackage

// File: rtl/biquad_sequencer_if.sv
// Control and coefficient bus between the sequencer and the two biquad channels.
interface biquad_sequencer_if
  import biquad_pkg::*;
;
  logic                AUD_DACLRCK;
  logic                filter_enable;
  logic                preset_req;
  logic [PRESET_W-1:0] preset_sel;
  logic                new_sample;
  logic                new_coefficients;
  coef_t               a0, a1, a2, b1, b2;
  logic [PRESET_W-1:0] preset_active;
  logic                busy;

  modport master (
    input  AUD_DACLRCK, filter_enable, preset_req, preset_sel,
    output new_sample, new_coefficients, a0, a1, a2, b1, b2, preset_active, busy
  );

  modport slave (
    output AUD_DACLRCK, filter_enable, preset_req, preset_sel,
    input  new_sample, new_coefficients, a0, a1, a2, b1, b2, preset_active, busy
  );
endinterface

// File: rtl/biquad_coef_rom.sv
// Synchronous-read coefficient ROM, one cycle of latency, contents from PRESET_COEFS.
module biquad_coef_rom
  import biquad_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROM_AW-1:0] addr,
  output coef_t             data
);

  coef_t data_d, data_q;

  // Constant-table lookup; addresses past the table read as zero.
  function automatic coef_t rom_read(input logic [ROM_AW-1:0] a);
    coef_t v;
    v = '0;
    for (int p = 0; p < NUM_PRESETS; p++) begin
      for (int c = 0; c < NUM_COEFS; c++) begin
        if (int'(a) == p * NUM_COEFS + c) begin
          v = PRESET_COEFS[p][c];
        end else begin
          v = v;
        end
      end
    end
    return v;
  endfunction

  // Decode the table entry for the presented address.
  always_comb begin
    data_d = rom_read(addr);
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/biquad_sequencer.sv
// LRCK strobe generation and sample-aligned coefficient preset loading for the biquad pair.
module biquad_sequencer
  import biquad_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic                CLOCK_50,
  input logic                Reset_n,
  biquad_sequencer_if.master bus
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lrck_prev_q, lrck_prev_d;
  logic                   edge_q, edge_d;
  logic                   new_sample_q, new_sample_d;
  seq_state_t             state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic [PRESET_W-1:0]    load_idx_q, load_idx_d;
  logic [PRESET_W-1:0]    pend_idx_q, pend_idx_d;
  logic [PRESET_W-1:0]    preset_active_q, preset_active_d;
  logic                   pend_valid_q, pend_valid_d;
  logic                   new_coef_q, new_coef_d;
  logic                   busy_q, busy_d;
  coef_t                  coef_q [NUM_COEFS];
  coef_t                  coef_d [NUM_COEFS];
  logic [ROM_AW-1:0]      rom_addr_s;
  coef_t                  rom_data_s;
  coef_idx_t              cap_idx_s;

  biquad_coef_rom u_rom (
    .clk   (CLOCK_50),
    .rst_n (Reset_n),
    .addr  (rom_addr_s),
    .data  (rom_data_s)
  );

  // Synchronize LRCK, detect its rising edge, and gate the sample strobe.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], bus.AUD_DACLRCK};
    lrck_prev_d  = sync_q[SYNC_STAGES-1];
    edge_d       = sync_q[SYNC_STAGES-1] & ~lrck_prev_q;
    new_sample_d = edge_q & bus.filter_enable;
  end

  // Load sequencing: pending request capture, edge wait, ROM fetch, strobe.
  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    load_idx_d      = load_idx_q;
    pend_valid_d    = pend_valid_q;
    pend_idx_d      = pend_idx_q;
    preset_active_d = preset_active_q;
    coef_d          = coef_q;
    new_coef_d      = 1'b0;
    rom_addr_s      = '0;
    cap_idx_s       = A0;

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          state_d      = WAIT_EDGE;
          load_idx_d   = pend_idx_q;
          pend_valid_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_EDGE: begin
        // Load starts on the sample boundary even when samples are gated off.
        if (edge_q) begin
          state_d = FETCH;
          k_d     = 3'd0;
        end else begin
          state_d = WAIT_EDGE;
        end
      end
      FETCH: begin
        if (k_q < 3'd5) begin
          rom_addr_s = rom_addr(load_idx_q, k_q);
        end else begin
          rom_addr_s = '0;
        end
        // ROM data lags the address by one cycle, so step k captures entry k-1.
        if (k_q != 3'd0) begin
          cap_idx_s         = coef_idx_t'(k_q - 3'd1);
          coef_d[cap_idx_s] = rom_data_s;
        end else begin
          cap_idx_s = A0;
        end
        if (k_q == 3'd5) begin
          state_d         = STROBE;
          k_d             = 3'd0;
          new_coef_d      = 1'b1;
          preset_active_d = load_idx_q;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      STROBE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A request in the consuming cycle survives and is served by the next load.
    if (bus.preset_req) begin
      pend_valid_d = 1'b1;
      pend_idx_d   = bus.preset_sel;
    end else begin
      pend_idx_d = pend_idx_d;
    end

    busy_d = pend_valid_d | (state_d != IDLE);
  end

  // State and output registers; reset queues an automatic preset-0 load.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q          <= '0;
      lrck_prev_q     <= 1'b0;
      edge_q          <= 1'b0;
      new_sample_q    <= 1'b0;
      state_q         <= IDLE;
      k_q             <= 3'd0;
      load_idx_q      <= '0;
      pend_valid_q    <= 1'b1;
      pend_idx_q      <= '0;
      preset_active_q <= '0;
      new_coef_q      <= 1'b0;
      busy_q          <= 1'b1;
      coef_q          <= '{default: '0};
    end else begin
      sync_q          <= sync_d;
      lrck_prev_q     <= lrck_prev_d;
      edge_q          <= edge_d;
      new_sample_q    <= new_sample_d;
      state_q         <= state_d;
      k_q             <= k_d;
      load_idx_q      <= load_idx_d;
      pend_valid_q    <= pend_valid_d;
      pend_idx_q      <= pend_idx_d;
      preset_active_q <= preset_active_d;
      new_coef_q      <= new_coef_d;
      busy_q          <= busy_d;
      coef_q          <= coef_d;
    end
  end

  assign bus.new_sample       = new_sample_q;
  assign bus.new_coefficients = new_coef_q;
  assign bus.a0               = coef_q[A0];
  assign bus.a1               = coef_q[A1];
  assign bus.a2               = coef_q[A2];
  assign bus.b1               = coef_q[B1];
  assign bus.b2               = coef_q[B2];
  assign bus.preset_active    = preset_active_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_biquad_sequencer.sv
// Directed bench for biquad_sequencer: reset, LRCK strobe, preset loading, reset mid-load.
module tb_biquad_sequencer;

  logic CLOCK_50;
  logic Reset_n;
  int   total;
  int   passed;
  int   ns_cnt;
  int   nc_cnt;

  // Hand-entered Q2.16 presets: a0, a1, a2, b1, b2.
  int exp_tab [8][5] = '{
    '{65536, 0,     0,     0,      0    },
    '{4096,  8192,  4096,  -98304, 40960},
    '{8192,  16384, 8192,  -81920, 32768},
    '{12288, 24576, 12288, -65536, 24576},
    '{16384, 32768, 16384, -49152, 16384},
    '{20480, 40960, 20480, -32768, 12288},
    '{24576, 49152, 24576, -16384, 8192 },
    '{28672, 57344, 28672, 0,      4096 }
  };

  biquad_sequencer_if bus ();

  biquad_sequencer #(.SYNC_STAGES(2)) dut (
    .CLOCK_50 (CLOCK_50),
    .Reset_n  (Reset_n),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Free-running strobe counters, sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (bus.new_sample === 1'b1) ns_cnt = ns_cnt + 1;
    if (bus.new_coefficients === 1'b1) nc_cnt = nc_cnt + 1;
  end

  function automatic logic [89:0] exp_vec(input int p);
    return {18'(exp_tab[p][0]), 18'(exp_tab[p][1]), 18'(exp_tab[p][2]),
            18'(exp_tab[p][3]), 18'(exp_tab[p][4])};
  endfunction

  function automatic logic [89:0] cur_vec();
    return {bus.a0, bus.a1, bus.a2, bus.b1, bus.b2};
  endfunction

  task automatic request(input int p);
    @(negedge CLOCK_50);
    bus.preset_req = 1'b1;
    bus.preset_sel = 3'(p);
    @(negedge CLOCK_50);
    bus.preset_req = 1'b0;
  endtask

  // Raise LRCK at a falling edge, then wait (bounded) for new_sample; n = cycles waited.
  task automatic rise_and_wait(output int n, output bit found);
    @(negedge CLOCK_50);
    bus.AUD_DACLRCK = 1'b1;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge CLOCK_50);
      if (!found && bus.new_sample === 1'b1) begin
        found = 1'b1;
        n = i;
        break;
      end
    end
  endtask

  task automatic finish_frame();
    repeat (12) @(negedge CLOCK_50);
    bus.AUD_DACLRCK = 1'b0;
    repeat (20) @(negedge CLOCK_50);
  endtask

  task automatic chk_found(input string name, input bit found);
    total++;
    if (!found) $display("FAIL %s: new_sample not seen within 50 cycles (required a pulse)", name);
    else passed++;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    bus.AUD_DACLRCK = 1'b0;
    bus.filter_enable = 1'b1;
    bus.preset_req = 1'b0;
    bus.preset_sel = 3'd0;
    repeat (3) @(negedge CLOCK_50);
    total++;
    if (cur_vec() !== 90'd0) $display("FAIL reset_coefs: got %h required 0", cur_vec());
    else passed++;
    total++;
    if ({bus.new_sample, bus.new_coefficients} !== 2'b00)
      $display("FAIL reset_strobes: got %b required 00", {bus.new_sample, bus.new_coefficients});
    else passed++;
    total++;
    if (bus.preset_active !== 3'd0) $display("FAIL reset_active: got %0d required 0", bus.preset_active);
    else passed++;
    total++;
    if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %b required 1", bus.busy);
    else passed++;
    Reset_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    total++;
    if (bus.busy !== 1'b1 || bus.new_coefficients !== 1'b0)
      $display("FAIL wait_busy: busy %b strobe %b required 1 0", bus.busy, bus.new_coefficients);
    else passed++;
  endtask

  task automatic test_first_edge();
    int n;
    bit found;
    rise_and_wait(n, found);
    chk_found("first_edge", found);
    total++;
    if (n !== 4) $display("FAIL sample_latency: got %0d required 4 half-offset cycles", n);
    else passed++;
    total++;
    if (cur_vec() !== 90'd0) $display("FAIL first_hold: got %h required 0", cur_vec());
    else passed++;
    @(negedge CLOCK_50);
    total++;
    if (bus.new_sample !== 1'b0) $display("FAIL sample_width: got %b required 0", bus.new_sample);
    else passed++;
    repeat (5) @(negedge CLOCK_50);
    total++;
    if (bus.new_coefficients !== 1'b1) $display("FAIL first_strobe: got %b required 1", bus.new_coefficients);
    else passed++;
    total++;
    if (cur_vec() !== exp_vec(0)) $display("FAIL first_coefs: got %h required %h", cur_vec(), exp_vec(0));
    else passed++;
    @(negedge CLOCK_50);
    total++;
    if ({bus.new_coefficients, bus.busy} !== 2'b00)
      $display("FAIL first_done: strobe,busy %b required 00", {bus.new_coefficients, bus.busy});
    else passed++;
    finish_frame();
  endtask

  task automatic test_filter_disable();
    int ns0, nc0;
    bus.filter_enable = 1'b0;
    ns0 = ns_cnt;
    nc0 = nc_cnt;
    request(1);
    for (int f = 0; f < 4; f++) begin
      @(negedge CLOCK_50);
      bus.AUD_DACLRCK = 1'b1;
      repeat (20) @(negedge CLOCK_50);
      bus.AUD_DACLRCK = 1'b0;
      repeat (20) @(negedge CLOCK_50);
    end
    total++;
    if (ns_cnt - ns0 !== 0) $display("FAIL disabled_samples: got %0d required 0", ns_cnt - ns0);
    else passed++;
    total++;
    if (nc_cnt - nc0 !== 1) $display("FAIL disabled_load: got %0d strobes required 1", nc_cnt - nc0);
    else passed++;
    total++;
    if (cur_vec() !== exp_vec(1) || bus.preset_active !== 3'd1)
      $display("FAIL disabled_coefs: got %h/%0d required %h/1", cur_vec(), bus.preset_active, exp_vec(1));
    else passed++;
    bus.filter_enable = 1'b1;
  endtask

  task automatic test_preset3();
    int n;
    bit found;
    request(3);
    repeat (3) @(negedge CLOCK_50);
    total++;
    if (bus.busy !== 1'b1 || cur_vec() !== exp_vec(1))
      $display("FAIL p3_pending: busy %b coefs %h required 1 %h", bus.busy, cur_vec(), exp_vec(1));
    else passed++;
    rise_and_wait(n, found);
    chk_found("p3_edge", found);
    total++;
    if (cur_vec() !== exp_vec(1)) $display("FAIL p3_hold: got %h required %h", cur_vec(), exp_vec(1));
    else passed++;
    repeat (6) @(negedge CLOCK_50);
    total++;
    if (bus.new_coefficients !== 1'b1 || cur_vec() !== exp_vec(3))
      $display("FAIL p3_load: strobe %b coefs %h required 1 %h", bus.new_coefficients, cur_vec(), exp_vec(3));
    else passed++;
    total++;
    if (bus.preset_active !== 3'd3) $display("FAIL p3_active: got %0d required 3", bus.preset_active);
    else passed++;
    finish_frame();
  endtask

  task automatic test_back_to_back();
    int n;
    bit found;
    request(4);
    rise_and_wait(n, found);
    chk_found("b2b_edge1", found);
    bus.preset_req = 1'b1;
    bus.preset_sel = 3'd2;
    @(negedge CLOCK_50);
    bus.preset_sel = 3'd5;
    @(negedge CLOCK_50);
    bus.preset_req = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    total++;
    if (bus.new_coefficients !== 1'b1 || cur_vec() !== exp_vec(4))
      $display("FAIL b2b_load4: strobe %b coefs %h required 1 %h", bus.new_coefficients, cur_vec(), exp_vec(4));
    else passed++;
    @(negedge CLOCK_50);
    total++;
    if (bus.busy !== 1'b1) $display("FAIL b2b_pending: busy %b required 1", bus.busy);
    else passed++;
    finish_frame();
    total++;
    if (bus.preset_active !== 3'd4 || cur_vec() !== exp_vec(4))
      $display("FAIL b2b_wait: active %0d coefs %h required 4 %h", bus.preset_active, cur_vec(), exp_vec(4));
    else passed++;
    rise_and_wait(n, found);
    chk_found("b2b_edge2", found);
    bus.preset_req = 1'b1;
    bus.preset_sel = 3'd6;
    @(negedge CLOCK_50);
    bus.preset_req = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    total++;
    if (bus.new_coefficients !== 1'b1 || cur_vec() !== exp_vec(5) || bus.preset_active !== 3'd5)
      $display("FAIL b2b_load5: strobe %b coefs %h active %0d required 1 %h 5",
               bus.new_coefficients, cur_vec(), bus.preset_active, exp_vec(5));
    else passed++;
    finish_frame();
    rise_and_wait(n, found);
    chk_found("b2b_edge3", found);
    repeat (6) @(negedge CLOCK_50);
    total++;
    if (bus.new_coefficients !== 1'b1 || cur_vec() !== exp_vec(6) || bus.preset_active !== 3'd6)
      $display("FAIL b2b_load6: strobe %b coefs %h active %0d required 1 %h 6",
               bus.new_coefficients, cur_vec(), bus.preset_active, exp_vec(6));
    else passed++;
    finish_frame();
  endtask

  task automatic test_reset_mid_fetch();
    int n, nc0;
    bit found;
    request(3);
    rise_and_wait(n, found);
    chk_found("mid_edge", found);
    repeat (2) @(negedge CLOCK_50);
    Reset_n = 1'b0;
    bus.AUD_DACLRCK = 1'b0;
    nc0 = nc_cnt;
    @(negedge CLOCK_50);
    total++;
    if (cur_vec() !== 90'd0 || bus.preset_active !== 3'd0 || bus.busy !== 1'b1)
      $display("FAIL mid_reset: coefs %h active %0d busy %b required 0 0 1", cur_vec(), bus.preset_active, bus.busy);
    else passed++;
    @(negedge CLOCK_50);
    Reset_n = 1'b1;
    repeat (15) @(negedge CLOCK_50);
    total++;
    if (nc_cnt - nc0 !== 0 || cur_vec() !== 90'd0)
      $display("FAIL mid_no_strobe: strobes %0d coefs %h required 0 0", nc_cnt - nc0, cur_vec());
    else passed++;
    rise_and_wait(n, found);
    chk_found("mid_edge2", found);
    repeat (6) @(negedge CLOCK_50);
    total++;
    if (bus.new_coefficients !== 1'b1 || cur_vec() !== exp_vec(0))
      $display("FAIL mid_reload0: strobe %b coefs %h required 1 %h", bus.new_coefficients, cur_vec(), exp_vec(0));
    else passed++;
    finish_frame();
  endtask

  task automatic test_glitch_free();
    int ns0, nc0;
    ns0 = ns_cnt;
    nc0 = nc_cnt;
    for (int f = 0; f < 1000; f++) begin
      @(negedge CLOCK_50);
      #($urandom_range(19, 0));
      bus.AUD_DACLRCK = 1'b1;
      repeat (20) @(negedge CLOCK_50);
      #($urandom_range(19, 0));
      bus.AUD_DACLRCK = 1'b0;
      repeat (20) @(negedge CLOCK_50);
    end
    repeat (10) @(negedge CLOCK_50);
    total++;
    if (ns_cnt - ns0 !== 1000) $display("FAIL glitch_count: got %0d required 1000", ns_cnt - ns0);
    else passed++;
    total++;
    if (nc_cnt - nc0 !== 0) $display("FAIL glitch_no_load: got %0d required 0", nc_cnt - nc0);
    else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    ns_cnt = 0;
    nc_cnt = 0;
    test_reset();
    test_first_edge();
    test_filter_disable();
    test_preset3();
    test_back_to_back();
    test_reset_mid_fetch();
    test_glitch_free();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
